fetch_queue: RTL and testbench

Instruction queue between the fetch stage and decode. Captures each instruction/PC pair produced by fetch into a small circular FIFO and presents them to decode over a valid/ready handshake. Back-pressures fetch through an almost-full stall signal that leaves one slot of skid for the instruction already in flight in program memory. Discards all queued entries on a pipeline flush (branch, jump or exception redirect).

---
 rtl/fetch_queue.sv | 99 +++++++++
 tb/tb_fetch_queue.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode: circular FIFO with valid/ready drain,
// almost-full stall and flush. Optional predecode flag via QU_FETCH_QUEUE_PREDECODE_EN.
module fetch_queue #(
    parameter int INSTR_WIDTH = 32,
    parameter int PC_WIDTH    = 12,
    parameter int DEPTH       = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [INSTR_WIDTH-1:0]   in_instr,
    input  logic [PC_WIDTH-1:0]      in_pc,
    output logic                     stall,
    output logic                     out_valid,
    output logic [INSTR_WIDTH-1:0]   out_instr,
    output logic [PC_WIDTH-1:0]      out_pc,
    output logic                     out_is_ctrl,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL   = CW'(DEPTH);
    localparam logic [CW-1:0] ALMOST = CW'(DEPTH - 1);

    logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
    logic [PC_WIDTH-1:0]    pc_mem    [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic                   push;
    logic                   pop;

    // Full check uses the pre-pop occupancy, so a pop never frees a slot for the same cycle.
    assign push = in_valid && (count != FULL);
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow     <= 1'b0;
            instr_mem[0] <= '0;
            pc_mem[0]    <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                instr_mem[wr_ptr] <= in_instr;
                pc_mem[wr_ptr]    <= in_pc;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (in_valid && (count == FULL)) begin
                overflow <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef QU_FETCH_QUEUE_PREDECODE_EN
    logic ctrl_mem [DEPTH];
    logic in_is_ctrl;

    assign in_is_ctrl = (in_instr[6:0] == 7'b1101111) ||
                        (in_instr[6:0] == 7'b1100111) ||
                        (in_instr[6:0] == 7'b1100011);

    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl_mem[0] <= 1'b0;
        end else if (!flush && push) begin
            ctrl_mem[wr_ptr] <= in_is_ctrl;
        end
    end

    assign out_is_ctrl = ctrl_mem[rd_ptr];
`else
    assign out_is_ctrl = 1'b0;
`endif

    assign out_valid = (count != '0);
    assign out_instr = instr_mem[rd_ptr];
    assign out_pc    = pc_mem[rd_ptr];
    assign stall     = (count >= ALMOST);

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios followed by random traffic,
// all compared against a queue-based reference model.
module tb_fetch_queue;
    localparam int IW = 32;
    localparam int PW = 12;
    localparam int D  = 4;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [IW-1:0] in_instr = '0;
    logic [PW-1:0] in_pc = '0;
    logic          out_ready = 1'b0;
    logic          stall;
    logic          out_valid;
    logic [IW-1:0] out_instr;
    logic [PW-1:0] out_pc;
    logic          out_is_ctrl;
    logic [CW-1:0] count;
    logic          overflow;

    fetch_queue #(.INSTR_WIDTH(IW), .PC_WIDTH(PW), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .in_instr(in_instr), .in_pc(in_pc), .stall(stall),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
        .out_is_ctrl(out_is_ctrl), .out_ready(out_ready),
        .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] instr;
        logic [PW-1:0] pc;
    } ent_t;

    ent_t q[$];
    logic m_ovf = 1'b0;
    int   checks = 0;
    int   failures = 0;

    function automatic logic ctrl_of(logic [IW-1:0] instr);
`ifdef QU_FETCH_QUEUE_PREDECODE_EN
        logic [6:0] op;
        op = instr[6:0];
        return (op == 7'h6F) || (op == 7'h67) || (op == 7'h63);
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() != 0));
        chk({tag, ".count"}, 64'(count), 64'(q.size()));
        chk({tag, ".stall"}, 64'(stall), 64'(q.size() >= D - 1));
        chk({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
        if (q.size() != 0) begin
            chk({tag, ".out_instr"}, 64'(out_instr), 64'(q[0].instr));
            chk({tag, ".out_pc"}, 64'(out_pc), 64'(q[0].pc));
            chk({tag, ".out_is_ctrl"}, 64'(out_is_ctrl), 64'(ctrl_of(q[0].instr)));
        end
    endtask

    // Drive one cycle of inputs, advance the model by the queue's rules, then compare.
    task automatic cycle(input string tag, input logic fl, input logic v,
                         input logic [IW-1:0] instr, input logic [PW-1:0] pc,
                         input logic rdy);
        bit full;
        flush = fl; in_valid = v; in_instr = instr; in_pc = pc; out_ready = rdy;
        @(posedge clk);
        if (fl) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            full = (q.size() == D);
            if (v && full) m_ovf = 1'b1;
            if (rdy && q.size() != 0) void'(q.pop_front());
            if (v && !full) q.push_back('{instr: instr, pc: pc});
        end
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        q.delete();
        m_ovf = 1'b0;
        #1;
        check_all(tag);
        chk({tag, ".out_instr"}, 64'(out_instr), 64'h0);
        chk({tag, ".out_pc"}, 64'(out_pc), 64'h0);
        chk({tag, ".out_is_ctrl"}, 64'(out_is_ctrl), 64'h0);
        rst = 1'b1;
    endtask

    initial begin
        logic [IW-1:0] ri;
        logic [PW-1:0] pc_ctr;
        do_reset("reset0");

        // Single push, visible next cycle
        cycle("push1", 0, 1, 32'h00500093, 12'h004, 0);
        chk("push1.const_instr", 64'(out_instr), 64'h00500093);
        chk("push1.const_pc", 64'(out_pc), 64'h004);
        chk("push1.const_count", 64'(count), 64'd1);
        chk("push1.const_stall", 64'(stall), 64'd0);

        // Fill to full, then overflow
        do_reset("reset1");
        cycle("fill0", 0, 1, 32'h11111113, 12'h000, 0);
        cycle("fill1", 0, 1, 32'h22222213, 12'h004, 0);
        chk("fill1.no_stall", 64'(stall), 64'd0);
        cycle("fill2", 0, 1, 32'h33333313, 12'h008, 0);
        chk("fill2.stall", 64'(stall), 64'd1);
        cycle("fill3", 0, 1, 32'h44444413, 12'h00C, 0);
        chk("fill3.count", 64'(count), 64'd4);
        chk("fill3.no_ovf", 64'(overflow), 64'd0);
        chk("fill3.head_pc", 64'(out_pc), 64'h000);
        cycle("fill4", 0, 1, 32'h55555513, 12'h010, 0);
        chk("fill4.ovf", 64'(overflow), 64'd1);
        chk("fill4.count", 64'(count), 64'd4);

        // Push and pop while full: pop wins, push dropped
        cycle("fullpp", 0, 1, 32'h66666613, 12'h014, 1);
        chk("fullpp.count", 64'(count), 64'd3);
        chk("fullpp.ovf", 64'(overflow), 64'd1);
        chk("fullpp.head_pc", 64'(out_pc), 64'h004);
        cycle("drain0", 0, 0, '0, '0, 1);
        chk("drain0.head_pc", 64'(out_pc), 64'h008);
        cycle("drain1", 0, 0, '0, '0, 1);
        chk("drain1.head_pc", 64'(out_pc), 64'h00C);
        cycle("drain2", 0, 0, '0, '0, 1);
        chk("drain2.valid", 64'(out_valid), 64'd0);
        chk("drain2.ovf_sticky", 64'(overflow), 64'd1);

        // Streaming with pointer wrap
        do_reset("reset2");
        cycle("stream_p", 0, 1, 32'h00000013, 12'h000, 0);
        for (int i = 1; i <= 10; i++) begin
            cycle("stream", 0, 1, 32'h00000013 | (i << 7), PW'(i * 4), 1);
            chk("stream.count", 64'(count), 64'd1);
            chk("stream.pc", 64'(out_pc), 64'(i * 4));
        end

        // Flush with concurrent push
        do_reset("reset3");
        cycle("fl_fill0", 0, 1, 32'hAAAA0013, 12'h020, 0);
        cycle("fl_fill1", 0, 1, 32'hBBBB0013, 12'h024, 0);
        cycle("fl_fill2", 0, 1, 32'hCCCC0013, 12'h028, 0);
        cycle("fl_ovf0", 0, 1, 32'hDDDD0013, 12'h02C, 0);
        cycle("fl_ovf1", 0, 1, 32'hEEEE0013, 12'h030, 0);
        cycle("fl_pop", 0, 0, '0, '0, 1);
        chk("fl_pre.count", 64'(count), 64'd3);
        cycle("flush", 1, 1, 32'hFFFF0013, 12'h034, 1);
        chk("flush.count", 64'(count), 64'd0);
        chk("flush.valid", 64'(out_valid), 64'd0);
        chk("flush.ovf", 64'(overflow), 64'd0);
        cycle("postfl", 0, 1, 32'h12340013, 12'h100, 0);
        chk("postfl.pc", 64'(out_pc), 64'h100);

        // Predecode flag
        do_reset("reset4");
        cycle("jal", 0, 1, 32'h0080006F, 12'h040, 0);
`ifdef QU_FETCH_QUEUE_PREDECODE_EN
        chk("jal.is_ctrl", 64'(out_is_ctrl), 64'd1);
`else
        chk("jal.is_ctrl", 64'(out_is_ctrl), 64'd0);
`endif
        cycle("nop", 0, 1, 32'h00000013, 12'h044, 1);
        chk("nop.is_ctrl", 64'(out_is_ctrl), 64'd0);

        // Random traffic
        pc_ctr = '0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset("rnd_reset");
            end else begin
                ri = $urandom;
                case ($urandom_range(0, 5))
                    0: ri[6:0] = 7'h6F;
                    1: ri[6:0] = 7'h67;
                    2: ri[6:0] = 7'h63;
                    default: ;
                endcase
                pc_ctr = pc_ctr + 12'h004;
                cycle("rnd", $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7,
                      ri, pc_ctr, $urandom_range(0, 9) < 5);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
